// File: rtl/i_rr_arbiter_n.sv
// i_rr_arbiter_n -- registered round-robin arbiter, active-low requests,
// active-low one-hot grant. grant_n_o is always all-ones or exactly one bit
// low, so the downstream one-hot-to-binary encoder never sees an illegal code.
// An owner keeps its grant until done_i; at least one idle cycle separates
// consecutive owners.
// Optional feature: define ARB_TIMEOUT_EN to build an 8-bit hold counter that
// forcibly releases a grant after HOLD_MAX cycles and pulses timeout_o.
module i_rr_arbiter_n #(
    parameter int SIZE     = 2,
    parameter int HOLD_MAX = 15
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [(2**SIZE)-1:0]   req_n_i,
    input  logic                   done_i,
    output logic [(2**SIZE)-1:0]   grant_n_o,
    output logic                   valid_o,
    output logic                   pend_o,
    output logic                   timeout_o
);

    localparam int N = 2**SIZE;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    // HOLD_MAX is stored in an 8-bit counter compare, so it must fit 1..255
    if ((HOLD_MAX < 1) || (HOLD_MAX > 255)) begin : g_hold_max_range
        $error("i_rr_arbiter_n: HOLD_MAX must be in 1..255");
    end

    state_t          state_q, state_d;
    logic [N-1:0]    grant_n_q, grant_n_d;
    logic            valid_q, valid_d;
    logic            pend_q, pend_d;
    logic [SIZE-1:0] last_q, last_d;
    logic [N-1:0]    req_s;
    logic [SIZE-1:0] pick_s;

`ifdef ARB_TIMEOUT_EN
    localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);
    logic [7:0]      hold_q, hold_d;
    logic            timeout_q, timeout_d;
`endif

    // Round-robin pick: first active request scanning last+1, last+2, ... mod N.
    // The index wraps naturally in SIZE bits, so last = N-1 starts at 0.
    function automatic logic [SIZE-1:0] rr_pick(input logic [N-1:0]    req,
                                                input logic [SIZE-1:0] last);
        logic [SIZE-1:0] idx;
        logic [SIZE-1:0] pick;
        logic            found;
        pick  = last;
        found = 1'b0;
        for (int k = 1; k <= N; k++) begin
            idx = last + SIZE'(k);
            if (!found && req[idx]) begin
                pick  = idx;
                found = 1'b1;
            end else begin
                found = found;
            end
        end
        return pick;
    endfunction

    assign req_s  = ~req_n_i;
    assign pick_s = rr_pick(req_s, last_q);

    // Next-state and next-output logic for the IDLE/GRANT controller
    always_comb begin
        state_d   = state_q;
        grant_n_d = grant_n_q;
        valid_d   = valid_q;
        last_d    = last_q;
`ifdef ARB_TIMEOUT_EN
        hold_d    = hold_q;
        timeout_d = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (|req_s) begin
                    grant_n_d = ~({{(N-1){1'b0}}, 1'b1} << pick_s);
                    valid_d   = 1'b1;
                    last_d    = pick_s;
                    state_d   = ST_GRANT;
`ifdef ARB_TIMEOUT_EN
                    hold_d    = 8'd0;
`endif
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_GRANT: begin
                // Release takes priority; new requests wait for the idle cycle
                if (done_i) begin
                    grant_n_d = {N{1'b1}};
                    valid_d   = 1'b0;
                    state_d   = ST_IDLE;
                end
`ifdef ARB_TIMEOUT_EN
                else if (hold_q == HOLD_LAST) begin
                    grant_n_d = {N{1'b1}};
                    valid_d   = 1'b0;
                    state_d   = ST_IDLE;
                    timeout_d = 1'b1;
                end else begin
                    hold_d = hold_q + 8'd1;
                end
`else
                else begin
                    state_d = ST_GRANT;
                end
`endif
            end
            default: begin
                grant_n_d = {N{1'b1}};
                valid_d   = 1'b0;
                state_d   = ST_IDLE;
            end
        endcase
        // Other requesters still waiting, relative to the grant about to be shown
        pend_d = |(req_s & grant_n_d);
    end

    // State, pointer and registered outputs
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            grant_n_q <= {N{1'b1}};
            valid_q   <= 1'b0;
            pend_q    <= 1'b0;
            last_q    <= {SIZE{1'b1}};
        end else begin
            state_q   <= state_d;
            grant_n_q <= grant_n_d;
            valid_q   <= valid_d;
            pend_q    <= pend_d;
            last_q    <= last_d;
        end
    end

`ifdef ARB_TIMEOUT_EN
    // Hold counter and one-cycle forced-release pulse
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            hold_q    <= 8'd0;
            timeout_q <= 1'b0;
        end else begin
            hold_q    <= hold_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout_o = timeout_q;
`else
    assign timeout_o = 1'b0;
`endif

    assign grant_n_o = grant_n_q;
    assign valid_o   = valid_q;
    assign pend_o    = pend_q;

endmodule

// File: doc/i_rr_arbiter_n.md
Name: i_rr_arbiter_n

Overview:
- Registered round-robin arbiter with active-low requests and an active-low one-hot grant.
- Sits directly upstream of the active-low one-hot to binary encoder stage (i_encoder4_2 family).
- Guarantees grant_n is always all-ones or has exactly one bit low, so the encoder never sees an illegal code.
- A requester holds its grant until it signals done.

Parameters:
- SIZE, 2, index width; number of requesters N = 2**SIZE.
- HOLD_MAX, 15, max grant length in cycles (used only with the optional feature); legal range 1..255.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- req_n  input  2**SIZE  active-low requests, bit i = requester i; synchronous to clk.
- done  input  1  active-high pulse; releases the current grant.
- grant_n  output  2**SIZE  active-low one-hot grant; all-ones = no grant; registered.
- valid  output  1  high while a grant is held; registered.
- pend  output  1  high when any request other than the granted one is low; registered.
- timeout  output  1  one-cycle pulse on forced release; tied 0 unless ARB_TIMEOUT_EN is defined.

Behaviour:
- Reset (async assert, sync release):
  - state = IDLE; grant_n = all ones; valid = 0; pend = 0; timeout = 0.
  - Pointer last = N-1, so requester 0 has first priority.
- States are IDLE and GRANT.
- IDLE:
  - If any req_n bit is 0 at a rising edge, select the first low bit scanning last+1, last+2, ... mod N.
  - On that same edge: grant_n has only the selected bit driven 0; valid = 1; last = selected index; state = GRANT.
  - Latency from request sampled to grant visible is 1 clock.
  - req_n all ones: remain in IDLE; outputs unchanged.
  - done is ignored in IDLE.
- GRANT:
  - grant_n and valid hold while done = 0.
  - Deasserting the granted req_n does not revoke the grant; only done (or timeout) releases it.
  - done = 1 at an edge: grant_n = all ones, valid = 0, state = IDLE.
  - There is always at least one idle cycle between grants, so the downstream encoder sees all-ones between owners.
  - New requests arriving during GRANT are not lost: they are arbitrated in the IDLE cycle after release.
- Round-robin fairness: after requester k is served, k has lowest priority at the next arbitration.
  - Example: with all requesters persistently low, grants go 0,1,2,3,0,... for N = 4.
- pend is computed each cycle as (any req_n low excluding the current granted bit) and registered with the other outputs.
- Wrap-around: the pointer increments modulo N; last = N-1 scans from index 0.
- Simultaneous done and new request in GRANT: release wins; arbitration happens on the following edge.
- Reset mid-grant: outputs return to reset values immediately (asynchronous), and the pointer resets to N-1.

Optional Feature:
- Macro ARB_TIMEOUT_EN.
- Defined:
  - An 8-bit hold counter clears on grant entry and increments each GRANT cycle without done.
  - When the counter reaches HOLD_MAX-1 and done = 0, the next edge forces release exactly as done does, and timeout pulses high for that one cycle.
  - The grant therefore lasts at most HOLD_MAX cycles.
  - The counter resets to 0.
- Not defined: no counter is built; timeout is constant 0; a grant lasts until done.

Test Plan:
- Reset check: assert rst mid-sim with grant active -> grant_n = 4'b1111, valid = 0, pend = 0 immediately; first request after release (req_n = 4'b0000) -> grant_n = 4'b1110.
- Single request: req_n = 4'b1011 at edge t -> at t+1 grant_n = 4'b1011, valid = 1; done at t+3 -> t+4 grant_n = 4'b1111, valid = 0.
- Rotation: req_n held 4'b0000, done pulsed on each grant cycle -> grant sequence 1110, 1101, 1011, 0111, 1110, with a 1111 cycle between each.
- Hold and pend: granted to requester 2 (grant_n = 4'b1011), then req_n = 4'b1110 and requester 2 drops -> grant_n stays 4'b1011, pend = 1; after done -> next grant 4'b1110.
- Idle stability: req_n = 4'b1111 with random done pulses for 20 cycles -> grant_n = 4'b1111, valid = 0 throughout.
- Timeout (ARB_TIMEOUT_EN, HOLD_MAX = 4): grant with done never asserted -> release after 4 valid cycles, timeout = 1 for one cycle, then grant_n = 4'b1111; without the macro the grant persists for 50+ cycles and timeout = 0.
